vram_sdp_fill: RTL and testbench

Parametrised simple-dual-port video RAM with one write port, one read port, a read-valid strobe and a hardware fill engine. After reset, or on request, the fill engine sweeps every word with a selectable pattern. It is the next generation of the fixed 8 KiB × 8 frame/tile store in the GPU memory subsystem. Render and scan-out logic connect to it directly.

---
 rtl/vram_sdp_fill.sv | 147 ++++++++++++++
 tb/tb_vram_sdp_fill.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_sdp_fill.sv
// Simple-dual-port video RAM with a hardware fill engine that sweeps the array after reset or on request.
// Defining VRAM_OUTREG_EN adds an output register stage, giving a read latency of 2 instead of 1.
module vram_sdp_fill #(
    parameter int          DATA_W     = 8,
    parameter int          ADDR_W     = 13,
    parameter int          FILL_MODE  = 1,
    parameter logic [63:0] FILL_VALUE = 64'd0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              fill_req,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);
    // state  | meaning
    // S_IDLE | user write/read ports own the array
    // S_FILL | fill engine writes one word per cycle at fill_cnt
    typedef enum logic {S_IDLE, S_FILL} state_t;

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int NB      = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;
    localparam bit FILL_EN = (FILL_MODE != 2);

    state_t            state;
    logic [ADDR_W-1:0] fill_cnt;
    logic              busy_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fill_word;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_q;
    logic              rv_q;

    always_comb begin
        fill_word = '0;
        if (FILL_MODE == 0) begin
            fill_word = FILL_VALUE[DATA_W-1:0];
        end else begin
            fill_word[NB-1:0] = fill_cnt[NB-1:0];
        end
    end

    // Single physical write port: the fill engine takes it over completely while filling.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = wdata;
        if (!i_rst) begin
            if (state == S_FILL) begin
                wr_en   = 1'b1;
                wr_addr = fill_cnt;
                wr_data = fill_word;
            end else begin
                wr_en = wen;
            end
        end
    end

    assign rd_en = !i_rst && (state == S_IDLE) && ren;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register samples the pre-write word, giving read-first behaviour on address collisions.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_en;
            if (rd_en) begin
                rd_q <= mem[raddr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill_cnt <= '0;
            if (FILL_EN) begin
                state  <= S_FILL;
                busy_q <= 1'b1;
            end else begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (fill_req && FILL_EN) begin
                        state    <= S_FILL;
                        busy_q   <= 1'b1;
                        fill_cnt <= '0;
                    end
                end
                S_FILL: begin
                    fill_cnt <= fill_cnt + ADDR_W'(1);
                    if (&fill_cnt) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef VRAM_OUTREG_EN
    logic [DATA_W-1:0] rd2_q;
    logic              rv2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd2_q <= '0;
            rv2_q <= 1'b0;
        end else begin
            rv2_q <= rv_q;
            if (rv_q) begin
                rd2_q <= rd_q;
            end
        end
    end

    assign rdata  = rd2_q;
    assign rvalid = rv2_q;
`else
    assign rdata  = rd_q;
    assign rvalid = rv_q;
`endif

    assign busy = busy_q;

endmodule

// File: tb/tb_vram_sdp_fill.sv
// Scoreboard bench for vram_sdp_fill: three instances cover address fill, constant fill and no-fill builds.
module tb_vram_sdp_fill;
`ifdef VRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       i_clk = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sbq[$];

    logic [2:0] rst;
    logic [2:0] freq;
    logic [2:0] wen;
    logic [2:0] ren;
    logic [2:0] rvalid;
    logic [2:0] busy;
    logic [3:0] waddr [3];
    logic [3:0] raddr [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // index 0: address pattern, 1: constant 0x5A, 2: no fill
    vram_sdp_fill #(.DATA_W(8), .ADDR_W(4), .FILL_MODE(1), .FILL_VALUE(64'h0)) dut_a (
        .i_clk(i_clk), .i_rst(rst[0]), .fill_req(freq[0]), .wen(wen[0]), .waddr(waddr[0]),
        .wdata(wdata[0]), .ren(ren[0]), .raddr(raddr[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
        .busy(busy[0]));
    vram_sdp_fill #(.DATA_W(8), .ADDR_W(4), .FILL_MODE(0), .FILL_VALUE(64'h5A)) dut_c (
        .i_clk(i_clk), .i_rst(rst[1]), .fill_req(freq[1]), .wen(wen[1]), .waddr(waddr[1]),
        .wdata(wdata[1]), .ren(ren[1]), .raddr(raddr[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
        .busy(busy[1]));
    vram_sdp_fill #(.DATA_W(8), .ADDR_W(4), .FILL_MODE(2), .FILL_VALUE(64'h0)) dut_n (
        .i_clk(i_clk), .i_rst(rst[2]), .fill_req(freq[2]), .wen(wen[2]), .waddr(waddr[2]),
        .wdata(wdata[2]), .ren(ren[2]), .raddr(raddr[2]), .rdata(rdata[2]), .rvalid(rvalid[2]),
        .busy(busy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic rd(input int k, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        ren[k]   = 1'b1;
        raddr[k] = a;
        e.id     = k;
        e.data   = d;
        e.due    = cyc + LAT;
        sbq.push_back(e);
    endtask

    task automatic count_busy(input int k, output int n);
        n = 0;
        while (busy[k] && n < 100) begin
            n++;
            @(negedge i_clk);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation, including its arrival cycle.
    always @(negedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rvalid[k]) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: dut %0d got data %0h at cycle %0d, required no rvalid",
                             k, rdata[k], cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rvalid_dut", 32'(k), 32'(e.id));
                    chk("rdata", 32'(rdata[k]), 32'(e.data));
                    chk("rd_latency_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        int n;
        rst  = 3'b111;
        freq = '0;
        wen  = '0;
        ren  = '0;
        for (int k = 0; k < 3; k++) begin
            waddr[k] = '0;
            raddr[k] = '0;
            wdata[k] = '0;
        end
        step();
        rst = '0;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata_a", 32'(rdata[0]), 32'h0);
        chk("rst_rdata_n", 32'(rdata[2]), 32'h0);
        chk("rst_busy", 32'(busy), 32'b011);

        // pattern fill after reset: 16 busy cycles, then address readback
        count_busy(0, n);
        chk("fill_len_reset", 32'(n), 32'd16);
        chk("busy_after_fill", 32'(busy), 32'h0);
        for (int a = 0; a < 16; a++) begin
            rd(0, a[3:0], a[7:0]);
            step();
        end
        ren[0] = 1'b0;

        // read-first collision, then new data visible next cycle
        wen[0] = 1'b1; waddr[0] = 4'h3; wdata[0] = 8'hA5;
        rd(0, 4'h3, 8'h03);
        step();
        wen[0] = 1'b0;
        rd(0, 4'h3, 8'hA5);
        step();
        ren[0] = 1'b0;
        repeat (3) step();
        chk("rdata_hold", 32'(rdata[0]), 32'hA5);

        // streaming reads 0..7
        for (int a = 0; a < 8; a++) begin
            rd(0, a[3:0], (a == 3) ? 8'hA5 : a[7:0]);
            step();
        end
        ren[0] = 1'b0;
        repeat (3) step();

        // fill_req alongside a user access, then reset part-way through the fill
        freq[0] = 1'b1; wen[0] = 1'b1; waddr[0] = 4'hC; wdata[0] = 8'hEE;
        rd(0, 4'hC, 8'h0C);
        step();
        freq[0] = 1'b0; wen[0] = 1'b0; ren[0] = 1'b1; raddr[0] = 4'h1;
        chk("busy_on_req", 32'(busy[0]), 32'h1);
        repeat (4) step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0; ren[0] = 1'b0;
        count_busy(0, n);
        chk("fill_len_restart", 32'(n), 32'd16);
        rd(0, 4'hC, 8'h0C); step();
        rd(0, 4'h3, 8'h03); step();
        rd(0, 4'hF, 8'h0F); step();
        ren[0] = 1'b0;
        repeat (3) step();

        // constant fill with user traffic blocked throughout
        wen[1] = 1'b1; waddr[1] = 4'h9; wdata[1] = 8'h11;
        step();
        wen[1] = 1'b0;
        freq[1] = 1'b1;
        step();
        freq[1] = 1'b0;
        wen[1] = 1'b1; waddr[1] = 4'h7; wdata[1] = 8'hFF;
        ren[1] = 1'b1; raddr[1] = 4'h7;
        count_busy(1, n);
        wen[1] = 1'b0; ren[1] = 1'b0;
        chk("fill_len_const", 32'(n), 32'd16);
        rd(1, 4'h7, 8'h5A); step();
        rd(1, 4'h9, 8'h5A); step();
        rd(1, 4'h0, 8'h5A); step();
        ren[1] = 1'b0;
        repeat (3) step();

        // no-fill build: fill_req with reset and alone are both ignored
        rst[2] = 1'b1; freq[2] = 1'b1;
        step();
        rst[2] = 1'b0; freq[2] = 1'b0;
        chk("nofill_busy_rst", 32'(busy[2]), 32'h0);
        wen[2] = 1'b1; waddr[2] = 4'h5; wdata[2] = 8'h3C;
        step();
        wen[2] = 1'b0;
        rd(2, 4'h5, 8'h3C);
        step();
        ren[2] = 1'b0;
        freq[2] = 1'b1;
        step();
        freq[2] = 1'b0;
        chk("nofill_busy_req", 32'(busy[2]), 32'h0);

        // reset right behind a read: only a latency-1 result escapes before reset
        ren[2] = 1'b1; raddr[2] = 4'h5;
        if (LAT == 1) begin
            exp_t e;
            e.id = 2; e.data = 8'h3C; e.due = cyc + 1;
            sbq.push_back(e);
        end
        step();
        ren[2] = 1'b0; rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        chk("rst_rdata_cleared", 32'(rdata[2]), 32'h0);
        chk("rst_rvalid_cleared", 32'(rvalid[2]), 32'h0);
        repeat (4) step();
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
